// File: rtl/axi_id_remap_pkg.sv
// Shared types and helpers for the AXI ID remap table. The types below are sized
// for the default build; the slot table derives its own widths from its parameters.
package axi_id_remap_pkg;

    localparam int DEF_ID_IN   = 8;
    localparam int DEF_ID_OUT  = 4;
    localparam int DEF_SLOTS   = 16;
    localparam int DEF_MAX_TXN = 4;
    // Widest free-slot vector the priority helper can scan.
    localparam int MAX_SLOTS   = 256;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SLOT_IDX_W = idx_width(DEF_SLOTS);
    localparam int CNT_W      = $clog2(DEF_MAX_TXN + 1);

    typedef logic [SLOT_IDX_W-1:0] slot_idx_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    typedef struct packed {
        logic                 valid;
        logic [DEF_ID_IN-1:0] in_id;
        cnt_t                 cnt;
    } slot_entry_t;

    // Index of the lowest set bit, or -1 when no bit is set.
    function automatic int lowest_free(input logic [MAX_SLOTS-1:0] free_vec);
        int idx;
        idx = -1;
        for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/id_remap_slot_table.sv
// One content-addressed ID slot table: lookup/allocate on the request side,
// restore/release on the response side, with a per-slot outstanding counter.
module id_remap_slot_table
    import axi_id_remap_pkg::*;
#(
    parameter int AXI_ID_IN  = 8,
    parameter int AXI_ID_OUT = 4,
    parameter int NUM_SLOTS  = 16,
    parameter int MAX_TXN    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXI_ID_IN-1:0]  i_req_id,
    input  logic                  i_req_fire,
    output logic                  o_req_ok,
    output logic [AXI_ID_OUT-1:0] o_req_slot,
    input  logic [AXI_ID_OUT-1:0] i_rsp_slot,
    input  logic                  i_rsp_release,
    output logic                  o_rsp_hit,
    output logic [AXI_ID_IN-1:0]  o_rsp_in_id
);

    localparam int IDX_W = idx_width(NUM_SLOTS);
    localparam int SC_W  = $clog2(MAX_TXN + 1);

    typedef struct packed {
        logic                 valid;
        logic [AXI_ID_IN-1:0] in_id;
        logic [SC_W-1:0]      cnt;
    } entry_t;

    entry_t               w_slot [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_hit_vec;
    logic [NUM_SLOTS-1:0] w_free_vec;
    logic [NUM_SLOTS-1:0] w_inc;
    logic [NUM_SLOTS-1:0] w_dec;

    logic                 w_hit;
    logic [IDX_W-1:0]     w_hit_idx;
    logic [SC_W-1:0]      w_hit_cnt;
    logic                 w_any_free;
    logic [IDX_W-1:0]     w_alloc_idx;
    logic [IDX_W-1:0]     w_sel_idx;
    int                   w_free_int;

    logic                 w_rsp_in_range;
    logic [IDX_W-1:0]     w_rsp_idx;
    logic                 w_rsp_valid;
    logic [AXI_ID_IN-1:0] w_rsp_in_id;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            entry_t r_entry;

            assign w_slot[gi]     = r_entry;
            assign w_hit_vec[gi]  = r_entry.valid && (r_entry.in_id == i_req_id);
            assign w_free_vec[gi] = !r_entry.valid;
            assign w_inc[gi]      = i_req_fire && (w_sel_idx == IDX_W'(gi));
            assign w_dec[gi]      = i_rsp_release && w_rsp_in_range &&
                                    (w_rsp_idx == IDX_W'(gi)) && r_entry.valid;

            // Request and release on the same slot cancel out, even at cnt==1.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_entry <= '0;
                end else begin
                    case ({w_inc[gi], w_dec[gi]})
                        2'b10: begin
                            if (r_entry.valid) begin
                                r_entry.cnt <= r_entry.cnt + SC_W'(1);
                            end else begin
                                r_entry.valid <= 1'b1;
                                r_entry.in_id <= i_req_id;
                                r_entry.cnt   <= SC_W'(1);
                            end
                        end
                        2'b01: begin
                            r_entry.cnt <= r_entry.cnt - SC_W'(1);
                            if (r_entry.cnt == SC_W'(1)) begin
                                r_entry.valid <= 1'b0;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    endgenerate

    // Allocation looks only at registered state, so a slot freed this cycle
    // becomes allocatable on the next one.
    always_comb begin
        w_hit_idx = '0;
        w_hit_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_hit_vec[i]) begin
                w_hit_idx = IDX_W'(i);
                w_hit_cnt = w_slot[i].cnt;
            end
        end
        w_hit       = |w_hit_vec;
        w_any_free  = |w_free_vec;
        w_free_int  = lowest_free(MAX_SLOTS'(w_free_vec));
        w_alloc_idx = IDX_W'(w_free_int);
        w_sel_idx   = w_hit ? w_hit_idx : w_alloc_idx;
        o_req_ok    = w_hit ? (w_hit_cnt < SC_W'(MAX_TXN)) : w_any_free;
        o_req_slot  = AXI_ID_OUT'(w_sel_idx);
    end

    always_comb begin
        w_rsp_in_range = (32'(i_rsp_slot) < 32'(NUM_SLOTS));
        w_rsp_idx      = IDX_W'(i_rsp_slot);
        w_rsp_valid    = 1'b0;
        w_rsp_in_id    = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_rsp_idx == IDX_W'(i)) begin
                w_rsp_valid = w_slot[i].valid;
                w_rsp_in_id = w_slot[i].in_id;
            end
        end
        o_rsp_hit   = w_rsp_in_range && w_rsp_valid;
        o_rsp_in_id = w_rsp_in_range ? w_rsp_in_id : '0;
    end

endmodule

// File: rtl/axi_id_remap_table.sv
// AXI ID remapper: wide master IDs onto a narrow slave ID space for AW/B and AR/R.
// Optional AXI_ID_REMAP_ERR_EN: drop responses to invalid slots and flag them on err_o.
module axi_id_remap_table
    import axi_id_remap_pkg::*;
#(
    parameter int AXI_ID_IN  = DEF_ID_IN,
    parameter int AXI_ID_OUT = DEF_ID_OUT,
    parameter int NUM_SLOTS  = DEF_SLOTS,
    parameter int MAX_TXN    = DEF_MAX_TXN,
    parameter int AW_PLD_W   = 64,
    parameter int RSP_PLD_W  = 72
) (
    input  logic                  clk,
    input  logic                  rst,
    // AW
    input  logic [AXI_ID_IN-1:0]  targ_aw_id_i,
    input  logic [AW_PLD_W-1:0]   targ_aw_pld_i,
    input  logic                  targ_aw_valid_i,
    output logic                  targ_aw_ready_o,
    output logic [AXI_ID_OUT-1:0] init_aw_id_o,
    output logic [AW_PLD_W-1:0]   init_aw_pld_o,
    output logic                  init_aw_valid_o,
    input  logic                  init_aw_ready_i,
    // B
    input  logic [AXI_ID_OUT-1:0] init_b_id_i,
    input  logic [RSP_PLD_W-1:0]  init_b_pld_i,
    input  logic                  init_b_valid_i,
    output logic                  init_b_ready_o,
    output logic [AXI_ID_IN-1:0]  targ_b_id_o,
    output logic [RSP_PLD_W-1:0]  targ_b_pld_o,
    output logic                  targ_b_valid_o,
    input  logic                  targ_b_ready_i,
    // AR
    input  logic [AXI_ID_IN-1:0]  targ_ar_id_i,
    input  logic [AW_PLD_W-1:0]   targ_ar_pld_i,
    input  logic                  targ_ar_valid_i,
    output logic                  targ_ar_ready_o,
    output logic [AXI_ID_OUT-1:0] init_ar_id_o,
    output logic [AW_PLD_W-1:0]   init_ar_pld_o,
    output logic                  init_ar_valid_o,
    input  logic                  init_ar_ready_i,
    // R
    input  logic [AXI_ID_OUT-1:0] init_r_id_i,
    input  logic [RSP_PLD_W-1:0]  init_r_pld_i,
    input  logic                  init_r_last_i,
    input  logic                  init_r_valid_i,
    output logic                  init_r_ready_o,
    output logic [AXI_ID_IN-1:0]  targ_r_id_o,
    output logic [RSP_PLD_W-1:0]  targ_r_pld_o,
    output logic                  targ_r_last_o,
    output logic                  targ_r_valid_o,
    input  logic                  targ_r_ready_i
`ifdef AXI_ID_REMAP_ERR_EN
    ,
    output logic                  err_o
`endif
);

    logic                  w_aw_ok;
    logic [AXI_ID_OUT-1:0] w_aw_slot;
    logic                  w_aw_fire;
    logic                  w_b_hit;
    logic [AXI_ID_IN-1:0]  w_b_in_id;
    logic                  w_b_release;

    logic                  w_ar_ok;
    logic [AXI_ID_OUT-1:0] w_ar_slot;
    logic                  w_ar_fire;
    logic                  w_r_hit;
    logic [AXI_ID_IN-1:0]  w_r_in_id;
    logic                  w_r_release;

    id_remap_slot_table #(
        .AXI_ID_IN  (AXI_ID_IN),
        .AXI_ID_OUT (AXI_ID_OUT),
        .NUM_SLOTS  (NUM_SLOTS),
        .MAX_TXN    (MAX_TXN)
    ) u_wr_table (
        .clk           (clk),
        .rst           (rst),
        .i_req_id      (targ_aw_id_i),
        .i_req_fire    (w_aw_fire),
        .o_req_ok      (w_aw_ok),
        .o_req_slot    (w_aw_slot),
        .i_rsp_slot    (init_b_id_i),
        .i_rsp_release (w_b_release),
        .o_rsp_hit     (w_b_hit),
        .o_rsp_in_id   (w_b_in_id)
    );

    id_remap_slot_table #(
        .AXI_ID_IN  (AXI_ID_IN),
        .AXI_ID_OUT (AXI_ID_OUT),
        .NUM_SLOTS  (NUM_SLOTS),
        .MAX_TXN    (MAX_TXN)
    ) u_rd_table (
        .clk           (clk),
        .rst           (rst),
        .i_req_id      (targ_ar_id_i),
        .i_req_fire    (w_ar_fire),
        .o_req_ok      (w_ar_ok),
        .o_req_slot    (w_ar_slot),
        .i_rsp_slot    (init_r_id_i),
        .i_rsp_release (w_r_release),
        .o_rsp_hit     (w_r_hit),
        .o_rsp_in_id   (w_r_in_id)
    );

    // Handshake outputs are forced low while reset is held, since an empty
    // table would otherwise accept everything.
    assign init_aw_valid_o = !rst && targ_aw_valid_i && w_aw_ok;
    assign targ_aw_ready_o = !rst && init_aw_ready_i && w_aw_ok;
    assign init_aw_id_o    = rst ? '0 : w_aw_slot;
    assign init_aw_pld_o   = targ_aw_pld_i;
    assign w_aw_fire       = !rst && targ_aw_valid_i && init_aw_ready_i && w_aw_ok;

    assign init_ar_valid_o = !rst && targ_ar_valid_i && w_ar_ok;
    assign targ_ar_ready_o = !rst && init_ar_ready_i && w_ar_ok;
    assign init_ar_id_o    = rst ? '0 : w_ar_slot;
    assign init_ar_pld_o   = targ_ar_pld_i;
    assign w_ar_fire       = !rst && targ_ar_valid_i && init_ar_ready_i && w_ar_ok;

    assign targ_b_valid_o  = !rst && init_b_valid_i && w_b_hit;
    assign targ_b_id_o     = rst ? '0 : w_b_in_id;
    assign targ_b_pld_o    = init_b_pld_i;
    assign w_b_release     = !rst && init_b_valid_i && targ_b_ready_i && w_b_hit;

    assign targ_r_valid_o  = !rst && init_r_valid_i && w_r_hit;
    assign targ_r_id_o     = rst ? '0 : w_r_in_id;
    assign targ_r_pld_o    = init_r_pld_i;
    assign targ_r_last_o   = init_r_last_i;
    assign w_r_release     = !rst && init_r_valid_i && targ_r_ready_i && w_r_hit && init_r_last_i;

`ifdef AXI_ID_REMAP_ERR_EN
    logic r_err;

    // Responses to unallocated slots are swallowed so the slave never hangs.
    assign init_b_ready_o = !rst && (w_b_hit ? targ_b_ready_i : 1'b1);
    assign init_r_ready_o = !rst && (w_r_hit ? targ_r_ready_i : 1'b1);
    assign err_o          = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((init_b_valid_i && !w_b_hit) || (init_r_valid_i && !w_r_hit)) begin
            r_err <= 1'b1;
        end
    end
`else
    assign init_b_ready_o = !rst && targ_b_ready_i && w_b_hit;
    assign init_r_ready_o = !rst && targ_r_ready_i && w_r_hit;
`endif

endmodule

// File: tb/tb_axi_id_remap_table.sv
// Directed self-checking bench for axi_id_remap_table (default parameters).
// Build with AXI_ID_REMAP_ERR_EN defined to also exercise err_o.
module tb_axi_id_remap_table;

    localparam int ID_IN  = 8;
    localparam int ID_OUT = 4;
    localparam int AW_W   = 64;
    localparam int RSP_W  = 72;
`ifdef AXI_ID_REMAP_ERR_EN
    localparam bit ERR_MODE = 1'b1;
`else
    localparam bit ERR_MODE = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [ID_IN-1:0]  targ_aw_id_i;
    logic [AW_W-1:0]   targ_aw_pld_i;
    logic              targ_aw_valid_i;
    logic              targ_aw_ready_o;
    logic [ID_OUT-1:0] init_aw_id_o;
    logic [AW_W-1:0]   init_aw_pld_o;
    logic              init_aw_valid_o;
    logic              init_aw_ready_i;
    logic [ID_OUT-1:0] init_b_id_i;
    logic [RSP_W-1:0]  init_b_pld_i;
    logic              init_b_valid_i;
    logic              init_b_ready_o;
    logic [ID_IN-1:0]  targ_b_id_o;
    logic [RSP_W-1:0]  targ_b_pld_o;
    logic              targ_b_valid_o;
    logic              targ_b_ready_i;
    logic [ID_IN-1:0]  targ_ar_id_i;
    logic [AW_W-1:0]   targ_ar_pld_i;
    logic              targ_ar_valid_i;
    logic              targ_ar_ready_o;
    logic [ID_OUT-1:0] init_ar_id_o;
    logic [AW_W-1:0]   init_ar_pld_o;
    logic              init_ar_valid_o;
    logic              init_ar_ready_i;
    logic [ID_OUT-1:0] init_r_id_i;
    logic [RSP_W-1:0]  init_r_pld_i;
    logic              init_r_last_i;
    logic              init_r_valid_i;
    logic              init_r_ready_o;
    logic [ID_IN-1:0]  targ_r_id_o;
    logic [RSP_W-1:0]  targ_r_pld_o;
    logic              targ_r_last_o;
    logic              targ_r_valid_o;
    logic              targ_r_ready_i;
`ifdef AXI_ID_REMAP_ERR_EN
    logic              err_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    axi_id_remap_table dut (
        .clk             (clk),
        .rst             (rst),
        .targ_aw_id_i    (targ_aw_id_i),
        .targ_aw_pld_i   (targ_aw_pld_i),
        .targ_aw_valid_i (targ_aw_valid_i),
        .targ_aw_ready_o (targ_aw_ready_o),
        .init_aw_id_o    (init_aw_id_o),
        .init_aw_pld_o   (init_aw_pld_o),
        .init_aw_valid_o (init_aw_valid_o),
        .init_aw_ready_i (init_aw_ready_i),
        .init_b_id_i     (init_b_id_i),
        .init_b_pld_i    (init_b_pld_i),
        .init_b_valid_i  (init_b_valid_i),
        .init_b_ready_o  (init_b_ready_o),
        .targ_b_id_o     (targ_b_id_o),
        .targ_b_pld_o    (targ_b_pld_o),
        .targ_b_valid_o  (targ_b_valid_o),
        .targ_b_ready_i  (targ_b_ready_i),
        .targ_ar_id_i    (targ_ar_id_i),
        .targ_ar_pld_i   (targ_ar_pld_i),
        .targ_ar_valid_i (targ_ar_valid_i),
        .targ_ar_ready_o (targ_ar_ready_o),
        .init_ar_id_o    (init_ar_id_o),
        .init_ar_pld_o   (init_ar_pld_o),
        .init_ar_valid_o (init_ar_valid_o),
        .init_ar_ready_i (init_ar_ready_i),
        .init_r_id_i     (init_r_id_i),
        .init_r_pld_i    (init_r_pld_i),
        .init_r_last_i   (init_r_last_i),
        .init_r_valid_i  (init_r_valid_i),
        .init_r_ready_o  (init_r_ready_o),
        .targ_r_id_o     (targ_r_id_o),
        .targ_r_pld_o    (targ_r_pld_o),
        .targ_r_last_o   (targ_r_last_o),
        .targ_r_valid_o  (targ_r_valid_o),
        .targ_r_ready_i  (targ_r_ready_i)
`ifdef AXI_ID_REMAP_ERR_EN
        ,
        .err_o           (err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks land 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [ID_IN-1:0] id, input logic [ID_OUT-1:0] exp_slot, input string tag);
        targ_aw_id_i    = id;
        targ_aw_pld_i   = {56'hA5A5_0000_1234_00, id};
        targ_aw_valid_i = 1'b1;
        init_aw_ready_i = 1'b1;
        #1;
        check({tag, ".valid"}, init_aw_valid_o, 1'b1);
        check({tag, ".id"}, init_aw_id_o, exp_slot);
        $display("AW  %s: in_id=0x%02h -> out_id=%0d", tag, id, init_aw_id_o);
        tick();
        targ_aw_valid_i = 1'b0;
    endtask

    task automatic aw_stall(input logic [ID_IN-1:0] id, input string tag);
        targ_aw_id_i    = id;
        targ_aw_valid_i = 1'b1;
        init_aw_ready_i = 1'b1;
        #1;
        check({tag, ".valid"}, init_aw_valid_o, 1'b0);
        check({tag, ".ready"}, targ_aw_ready_o, 1'b0);
        $display("AW  %s: in_id=0x%02h stall", tag, id);
        tick();
        targ_aw_valid_i = 1'b0;
    endtask

    task automatic b_send(input logic [ID_OUT-1:0] slot, input logic [ID_IN-1:0] exp_id, input string tag);
        init_b_id_i    = slot;
        init_b_pld_i   = {64'h0, 4'h0, slot, exp_id[3:0], exp_id[7:4]};
        init_b_valid_i = 1'b1;
        targ_b_ready_i = 1'b1;
        #1;
        check({tag, ".valid"}, targ_b_valid_o, 1'b1);
        check({tag, ".ready"}, init_b_ready_o, 1'b1);
        check({tag, ".id"}, targ_b_id_o, exp_id);
        $display("B   %s: slot=%0d -> in_id=0x%02h", tag, slot, targ_b_id_o);
        tick();
        init_b_valid_i = 1'b0;
    endtask

    // Response to an unallocated slot: stalled, or swallowed when the error feature is on.
    task automatic b_stall(input logic [ID_OUT-1:0] slot, input string tag);
        init_b_id_i    = slot;
        init_b_valid_i = 1'b1;
        targ_b_ready_i = 1'b1;
        #1;
        check({tag, ".valid"}, targ_b_valid_o, 1'b0);
        check({tag, ".ready"}, init_b_ready_o, ERR_MODE);
        $display("B   %s: slot=%0d invalid", tag, slot);
        tick();
        init_b_valid_i = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        targ_aw_id_i    = '0;
        targ_aw_pld_i   = '0;
        targ_aw_valid_i = 1'b1;
        init_aw_ready_i = 1'b1;
        init_b_id_i     = '0;
        init_b_pld_i    = '0;
        init_b_valid_i  = 1'b1;
        targ_b_ready_i  = 1'b1;
        targ_ar_id_i    = '0;
        targ_ar_pld_i   = '0;
        targ_ar_valid_i = 1'b1;
        init_ar_ready_i = 1'b1;
        init_r_id_i     = '0;
        init_r_pld_i    = '0;
        init_r_last_i   = 1'b0;
        init_r_valid_i  = 1'b0;
        targ_r_ready_i  = 1'b1;

        // Reset state: everything quiet despite active inputs.
        #2;
        check("rst.aw_valid", init_aw_valid_o, 1'b0);
        check("rst.aw_ready", targ_aw_ready_o, 1'b0);
        check("rst.aw_id", init_aw_id_o, 4'h0);
        check("rst.b_valid", targ_b_valid_o, 1'b0);
        check("rst.b_ready", init_b_ready_o, 1'b0);
        check("rst.ar_valid", init_ar_valid_o, 1'b0);
        $display("RST outputs held low");
        targ_aw_valid_i = 1'b0;
        init_b_valid_i  = 1'b0;
        targ_ar_valid_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Shared output ID for repeated input ID.
        aw_send(8'h5A, 4'd0, "t1.aw0");
        check("t1.pld", init_aw_pld_o, {56'hA5A5_0000_1234_00, 8'h5A});
        aw_send(8'h5A, 4'd0, "t1.aw1");
        b_send(4'd0, 8'h5A, "t1.b0");
        b_send(4'd0, 8'h5A, "t1.b1");
        b_stall(4'd0, "t1.freed");

        // Fill all 16 slots, overflow, and reuse of a freed slot.
        for (int i = 0; i < 16; i++) begin
            aw_send(8'(i + 1), 4'(i), $sformatf("t2.fill%0d", i));
        end
        aw_stall(8'h11, "t2.full");
        targ_aw_id_i    = 8'h11;
        targ_aw_valid_i = 1'b1;
        init_b_id_i     = 4'd3;
        init_b_valid_i  = 1'b1;
        targ_b_ready_i  = 1'b1;
        #1;
        check("t2.same_cyc.aw_valid", init_aw_valid_o, 1'b0);
        check("t2.same_cyc.b_id", targ_b_id_o, 8'h04);
        $display("AW  t2: release slot 3 while 0x11 waits");
        tick();
        init_b_valid_i = 1'b0;
        #1;
        check("t2.next.aw_valid", init_aw_valid_o, 1'b1);
        check("t2.next.aw_id", init_aw_id_o, 4'd3);
        $display("AW  t2: in_id=0x11 -> out_id=%0d", init_aw_id_o);
        tick();
        targ_aw_valid_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b_send(4'(i), (i == 3) ? 8'h11 : 8'(i + 1), $sformatf("t2.drain%0d", i));
        end

        // Per-slot outstanding limit.
        for (int i = 0; i < 4; i++) begin
            aw_send(8'h22, 4'd0, $sformatf("t3.aw%0d", i));
        end
        aw_stall(8'h22, "t3.limit");
        targ_aw_id_i    = 8'h22;
        targ_aw_valid_i = 1'b1;
        init_b_id_i     = 4'd0;
        init_b_valid_i  = 1'b1;
        #1;
        check("t3.same_cyc.aw_valid", init_aw_valid_o, 1'b0);
        tick();
        init_b_valid_i = 1'b0;
        #1;
        check("t3.next.aw_valid", init_aw_valid_o, 1'b1);
        check("t3.next.aw_id", init_aw_id_o, 4'd0);
        $display("AW  t3: 5th 0x22 accepted after one B");
        tick();
        targ_aw_valid_i = 1'b0;
        aw_stall(8'h22, "t3.hold4");
        for (int i = 0; i < 4; i++) begin
            b_send(4'd0, 8'h22, $sformatf("t3.b%0d", i));
        end
        b_stall(4'd0, "t3.freed");

        // Read burst: only the last beat releases.
        targ_ar_id_i    = 8'h33;
        targ_ar_pld_i   = 64'h0000_0003_0000_1000;
        targ_ar_valid_i = 1'b1;
        init_ar_ready_i = 1'b1;
        #1;
        check("t4.ar_valid", init_ar_valid_o, 1'b1);
        check("t4.ar_ready", targ_ar_ready_o, 1'b1);
        check("t4.ar_id", init_ar_id_o, 4'd0);
        check("t4.ar_pld", init_ar_pld_o, 64'h0000_0003_0000_1000);
        $display("AR  t4: in_id=0x33 -> out_id=%0d", init_ar_id_o);
        tick();
        targ_ar_valid_i = 1'b0;
        for (int beat = 0; beat < 4; beat++) begin
            init_r_id_i    = 4'd0;
            init_r_pld_i   = 72'(beat) + 72'hF0;
            init_r_last_i  = (beat == 3);
            init_r_valid_i = 1'b1;
            targ_r_ready_i = 1'b1;
            #1;
            check($sformatf("t4.r%0d.valid", beat), targ_r_valid_o, 1'b1);
            check($sformatf("t4.r%0d.id", beat), targ_r_id_o, 8'h33);
            check($sformatf("t4.r%0d.last", beat), targ_r_last_o, (beat == 3));
            check($sformatf("t4.r%0d.pld", beat), targ_r_pld_o, 72'(beat) + 72'hF0);
            $display("R   t4: beat %0d id=0x%02h last=%0d", beat, targ_r_id_o, targ_r_last_o);
            tick();
        end
        init_r_last_i = 1'b0;
        #1;
        check("t4.freed.valid", targ_r_valid_o, 1'b0);
        $display("R   t4: slot 0 released");
        init_r_valid_i = 1'b0;
        tick();

        // Request and final release on slot 2 in the same cycle.
        aw_send(8'hA0, 4'd0, "t5.aw0");
        aw_send(8'hA1, 4'd1, "t5.aw1");
        aw_send(8'hA2, 4'd2, "t5.aw2");
        targ_aw_id_i    = 8'hA2;
        targ_aw_valid_i = 1'b1;
        init_b_id_i     = 4'd2;
        init_b_valid_i  = 1'b1;
        #1;
        check("t5.same.aw_valid", init_aw_valid_o, 1'b1);
        check("t5.same.aw_id", init_aw_id_o, 4'd2);
        check("t5.same.b_valid", targ_b_valid_o, 1'b1);
        $display("AW  t5: request + final B on slot 2 together");
        tick();
        targ_aw_valid_i = 1'b0;
        init_b_valid_i  = 1'b0;
        b_send(4'd2, 8'hA2, "t5.keep");
        b_stall(4'd2, "t5.freed");
        aw_send(8'hA3, 4'd2, "t5.realloc");

        // Asynchronous reset mid-cycle with traffic pending.
        targ_aw_id_i    = 8'hC0;
        targ_aw_valid_i = 1'b1;
        init_b_id_i     = 4'd0;
        init_b_valid_i  = 1'b1;
        targ_b_ready_i  = 1'b1;
        #1;
        check("t6.pre.aw_id", init_aw_id_o, 4'd3);
        check("t6.pre.b_id", targ_b_id_o, 8'hA0);
        #2;
        rst = 1'b1;
        #1;
        check("t6.rst.aw_valid", init_aw_valid_o, 1'b0);
        check("t6.rst.aw_ready", targ_aw_ready_o, 1'b0);
        check("t6.rst.b_valid", targ_b_valid_o, 1'b0);
        check("t6.rst.b_ready", init_b_ready_o, 1'b0);
        check("t6.rst.b_id", targ_b_id_o, 8'h00);
        $display("RST t6: asserted mid-cycle");
        targ_aw_valid_i = 1'b0;
        init_b_valid_i  = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        b_stall(4'd0, "t6.cleared0");
        b_stall(4'd2, "t6.cleared2");
        aw_send(8'hB0, 4'd0, "t6.aw0");
        aw_send(8'hB1, 4'd1, "t6.aw1");

`ifdef AXI_ID_REMAP_ERR_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("t7.err_init", err_o, 1'b0);
        init_b_id_i    = 4'd7;
        init_b_valid_i = 1'b1;
        targ_b_ready_i = 1'b0;
        #1;
        check("t7.drop.ready", init_b_ready_o, 1'b1);
        check("t7.drop.valid", targ_b_valid_o, 1'b0);
        tick();
        init_b_valid_i = 1'b0;
        check("t7.err_set", err_o, 1'b1);
        tick();
        tick();
        check("t7.err_sticky", err_o, 1'b1);
        $display("ERR t7: err_o=%0d after dropped B on slot 7", err_o);
        rst = 1'b1;
        #1;
        check("t7.err_clr", err_o, 1'b0);
        tick();
        rst = 1'b0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/axi_id_remap_table.md
Name: axi_id_remap_table

Overview:
- Parametrised successor to the fixed-depth AXI ID remapper. Compresses wide master-side IDs (AXI_ID_IN) onto a narrow slave-side ID space (AXI_ID_OUT) for both the write (AW/B) and read (AR/R) paths.
- Each path uses a content-addressed slot table with a per-slot outstanding counter. Multiple in-flight transactions with the same input ID share one output ID, which preserves AXI same-ID ordering.
- Sits between an interconnect master port and a narrow-ID slave. Non-ID payloads are carried as opaque bundled vectors and pass through combinationally.

Parameters:
- AXI_ID_IN, 8, master-side ID width.
- AXI_ID_OUT, 4, slave-side ID width.
- NUM_SLOTS, 16, table entries per path; must be <= 2**AXI_ID_OUT and >= 1.
- MAX_TXN, 4, maximum outstanding transactions per slot (>= 1).
- AW_PLD_W, 64, width of the bundled AW/AR payload (addr, len, size, burst, lock, cache, prot, region, qos, user).
- RSP_PLD_W, 72, width of the bundled B/R payload (data, resp, user; for R also last, carried separately).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- targ_aw_id_i  in  AXI_ID_IN  master AW ID.
- targ_aw_pld_i  in  AW_PLD_W  AW payload.
- targ_aw_valid_i / targ_aw_ready_o  in/out  1  AW handshake.
- init_aw_id_o  out  AXI_ID_OUT  remapped AW ID.
- init_aw_pld_o  out  AW_PLD_W  AW payload.
- init_aw_valid_o / init_aw_ready_i  out/in  1  AW handshake.
- init_b_id_i  in  AXI_ID_OUT  slave B ID.
- init_b_pld_i  in  RSP_PLD_W  B payload.
- init_b_valid_i / init_b_ready_o  in/out  1  B handshake.
- targ_b_id_o  out  AXI_ID_IN  restored B ID.
- targ_b_pld_o  out  RSP_PLD_W  B payload.
- targ_b_valid_o / targ_b_ready_i  out/in  1  B handshake.
- targ_ar_*, init_ar_*  same set as AW for the read path.
- init_r_*, targ_r_*  same set as B, plus init_r_last_i in 1 and targ_r_last_o out 1.

Behaviour:
- Reset (asynchronous, rst=1): all slots invalid, all counters 0. All valid/ready outputs 0 while reset is asserted; ID outputs 0.
- Slot state per path: valid bit, stored in_id[AXI_ID_IN], cnt[$clog2(MAX_TXN+1)].
- Request lookup (combinational on targ_*_id_i):
  - hit = a valid slot whose in_id matches.
  - With a hit, accept only if cnt < MAX_TXN; otherwise stall.
  - With a miss, allocate the lowest-index invalid slot; if there is none, stall.
- Request gating:
  - accept = lookup OK.
  - init_*_valid_o = targ_*_valid_i & accept.
  - targ_*_ready_o = init_*_ready_i & accept.
  - Zero added latency; valid never depends on ready.
- Output ID = chosen slot index, zero-extended to AXI_ID_OUT.
- On request handshake: hit → cnt+1; miss → slot valid=1, in_id stored, cnt=1.
- Response lookup: slot = init_*_id_i (index).
  - targ_*_id_o = slot in_id.
  - targ_*_valid_o = init_*_valid_i & slot valid.
  - init_*_ready_o = targ_*_ready_i & slot valid.
- Release:
  - B: on every B handshake.
  - R: on an R handshake with init_r_last_i=1 only.
  - Release does cnt-1; when cnt reaches 0 the slot becomes invalid.
- Simultaneous request and release on the same slot: net cnt unchanged and the slot stays valid, even when cnt was 1.
- Simultaneous release-to-zero and a miss allocation: the freed slot is not reusable until the next cycle. The allocator uses registered state only.
- Response to an invalid slot (protocol error): the response is stalled indefinitely unless AXI_ID_REMAP_ERR_EN is defined.
- The two paths are fully independent. The R payload and last pass straight through.

Optional Feature:
- Macro: AXI_ID_REMAP_ERR_EN.
- Defined:
  - Adds port err_o (out, 1), a sticky bit set when a response arrives with init_*_valid_i=1 for an invalid slot; cleared only by rst.
  - Such responses are dropped: init_*_ready_o=1, targ_*_valid_o=0.
- Undefined: no err_o port; such responses stall as described in Behaviour.

Decomposition:
- Package axi_id_remap_pkg holds:
  - slot_idx_t ($clog2(NUM_SLOTS) bits, minimum 1);
  - cnt_t;
  - the slot_entry_t struct (valid, in_id, cnt);
  - a lowest-free-slot priority function.
- Sub-module id_remap_slot_table: one table with lookup, allocate and release logic.
- The top instantiates id_remap_slot_table twice, for AW/B and AR/R, and adds the handshake gating.

Test Plan:
- AW id 0x5A, then id 0x5A again, both accepted → init_aw_id_o=0 both times; slot0 cnt=2. Two B responses with id 0 → targ_b_id_o=0x5A twice; slot0 invalid afterwards.
- AW ids 0x01..0x10 (16 distinct, NUM_SLOTS=16), no B → output IDs 0..15. A 17th id 0x11 → init_aw_valid_o=0 and targ_aw_ready_o=0 until one B for slot 3 frees it; 0x11 then maps to 3 on the following cycle.
- Same id 0x22 issued 5 times, MAX_TXN=4 → the 5th stalls. It is accepted on the cycle after the first B; cnt holds at 4.
- AR id 0x33 with len=3 → R beats 0..2 do not release the slot. Beat 3 with last=1 releases it; all four beats carry targ_r_id_o=0x33.
- Request handshake and final B on slot 2 (cnt=1) in the same cycle → slot 2 stays valid with cnt=1. Separately, assert rst mid-burst → all slots cleared asynchronously and all valid/ready outputs 0.
- With AXI_ID_REMAP_ERR_EN defined, B with id 7 while slot 7 is invalid → dropped, err_o=1 until rst.
